// File: rtl/encoder_8x3_drain_pkg.sv
// Shared types and widths for the 8-to-3 draining encoder.
package encoder_pkg;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/encoder_8x3_drain_prio_enc.sv
// prio_enc_8x3: combinational priority encoder.
// MSB_FIRST=0 selects the lowest set bit and MSB_FIRST=1 selects the highest.
// onehot is high when exactly one bit of vec is set.
module prio_enc_8x3
  import encoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             onehot
);

  // Later loop iterations override earlier ones, so the scan direction sets the winner.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int unsigned i = VEC_W; i > 0; i--) begin
        if (vec[i-1]) idx = IDX_W'(i - 1);
      end
    end
  end

  // Exactly one bit is set when the vector is non-zero and clearing its lowest set bit leaves zero.
  always_comb begin
    onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  end

endmodule

// File: rtl/encoder_8x3_drain.sv
// encoder_8x3_drain: accepts an 8-bit request vector and emits the index of
// each set bit, one per cycle, through a valid/ready output handshake.
// Optional feature: define ENCODER_8X3_ZERO_ERR_EN to add the err output,
// which pulses for one cycle after an all-zero vector is accepted.
module encoder_8x3_drain
  import encoder_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef ENCODER_8X3_ZERO_ERR_EN
  ,
  output logic             err
`endif
);

  state_t           state;
  logic [VEC_W-1:0] pend;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_onehot;
  logic [VEC_W-1:0] clr_mask;
  logic             in_hs;
  logic             out_hs;

  prio_enc_8x3 #(
    .MSB_FIRST(MSB_FIRST)
  ) u_prio (
    .vec   (pend),
    .idx   (sel_idx),
    .onehot(sel_onehot)
  );

  // Outputs are decoded from state and pend only, so in_vec has no combinational path to them.
  always_comb begin
    in_ready  = en && (state == IDLE);
    out_valid = en && (state == DRAIN);
    out_idx   = sel_idx;
    out_last  = (state == DRAIN) && sel_onehot;
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    clr_mask  = VEC_W'(1) << sel_idx;
  end

  // Load non-zero vectors, then clear one selected bit per output handshake until empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else if (en) begin
      if (in_hs && (in_vec != '0)) begin
        pend  <= in_vec;
        state <= DRAIN;
      end else if (out_hs) begin
        pend <= pend & ~clr_mask;
        if (out_last) state <= IDLE;
      end
    end
  end

`ifdef ENCODER_8X3_ZERO_ERR_EN
  // One-cycle flag for a consumed all-zero vector; it is never held over while en is low.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= in_hs && (in_vec == '0);
  end
`endif

endmodule
